// File: rtl/boot_copy_ctrl.sv
`timescale 1ns/1ps
// boot_copy_ctrl
//   Boot-time sequencer that owns the shared data bus. After reset it copies
//   COPY_LEN bytes from flash (SRC_BASE) to RAM (DST_BASE) as read/write pairs,
//   two cycles per byte. While copying, the CPU is held off the bus. Once the
//   copy completes, the bus is handed to the CPU request port. A bus exception
//   during the copy parks the block in a sticky error state until rst.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   restart                  1-cycle pulse; in DONE re-runs the copy
//   cpu_req/rw/len/addr/wdata CPU access request (serviced only in DONE)
//   cpu_rdata                read data, straight from bus_rdata
//   cpu_ready                CPU access accepted this cycle
//   cpu_exception            bus exception seen by the CPU (DONE only)
//   bus_rw/len/addr/wdata    data bus command; a write commits at posedge
//   bus_rdata, bus_exception combinational responses from the data bus
//   busy, done, error        status: RD/WR, DONE, ERR
//   dbg_state                current FSM state (0=RD 1=WR 2=DONE 3=ERR)
//
// CPU handshake: cpu_req is the request valid and cpu_ready the grant. Both are
// evaluated within one cycle; an access transfers in every cycle where both are
// high. cpu_ready is combinational from cpu_req and the state, so the CPU must
// hold its request (address, data, type) stable until it sees cpu_ready.
module boot_copy_ctrl #(
    parameter logic [31:0] SRC_BASE = 32'h0010_0000,
    parameter logic [31:0] DST_BASE = 32'h0000_8000,
    parameter int          COPY_LEN = 261,
    parameter int          CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic        cpu_req,
    input  logic        cpu_rw,
    input  logic [1:0]  cpu_len,
    input  logic [31:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_exception,
    output logic        bus_rw,
    output logic [1:0]  bus_len,
    output logic [31:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_exception,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_RD   = 2'd0,
        S_WR   = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COPY_LEN - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       rd_buf;
    logic [31:0]      cnt_ext;

    assign cnt_ext = 32'(cnt);

    // State register. rd_buf captures the flash byte at the end of every RD
    // cycle; the following WR cycle drives it back out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_RD;
            cnt    <= '0;
            rd_buf <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_RD) begin
                rd_buf <= bus_rdata;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_RD: begin
                state_nxt = bus_exception ? S_ERR : S_WR;
            end
            S_WR: begin
                if (bus_exception) begin
                    state_nxt = S_ERR;
                end else if (cnt == LAST_IDX) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = S_RD;
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            S_DONE: begin
                // Restart wins over nothing else: the CPU access presented in
                // this same cycle is still driven and completes.
                if (restart) begin
                    state_nxt = S_RD;
                    cnt_nxt   = '0;
                end
            end
            // ERR is sticky; cnt stays frozen at the failing byte.
            default: begin
                state_nxt = S_ERR;
            end
        endcase
    end

    // Output logic. rst forces state to RD asynchronously, so bus_rw drops
    // to 0 as soon as rst rises.
    always_comb begin
        bus_rw    = 1'b0;
        bus_len   = 2'b00;
        bus_addr  = SRC_BASE + cnt_ext;
        bus_wdata = rd_buf;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            S_RD: begin
                busy = 1'b1;
            end
            S_WR: begin
                busy     = 1'b1;
                bus_rw   = 1'b1;
                bus_addr = DST_BASE + cnt_ext;
            end
            S_DONE: begin
                done      = 1'b1;
                bus_rw    = cpu_req & cpu_rw;
                bus_len   = cpu_len;
                bus_addr  = cpu_addr;
                bus_wdata = cpu_wdata;
            end
            default: begin
                error = 1'b1;
            end
        endcase
    end

    assign cpu_rdata     = bus_rdata;
    assign cpu_ready     = cpu_req & done;
    assign cpu_exception = bus_exception & done;
    assign dbg_state     = state;

endmodule

// File: tb/tb_boot_copy_ctrl.sv
`timescale 1ns/1ps
// Bench for boot_copy_ctrl. Two instances: dut_a with COPY_LEN=4 for the
// directed scenarios, dut_b with the default COPY_LEN=261 for the long copy.
// Every expected bus write is pushed into a per-instance queue before the
// stimulus that causes it; a monitor pops and compares on each write strobe.
module tb_boot_copy_ctrl;

    localparam logic [31:0] SRC = 32'h0010_0000;
    localparam logic [31:0] DST = 32'h0000_8000;
    localparam logic [31:0] BAD = 32'hDEAD_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    // ---------------- dut_a signals ----------------
    logic        restart_a, cpu_req_a, cpu_rw_a;
    logic [1:0]  cpu_len_a;
    logic [31:0] cpu_addr_a;
    logic [7:0]  cpu_wdata_a, cpu_rdata_a;
    logic        cpu_ready_a, cpu_exc_a;
    logic        bus_rw_a;
    logic [1:0]  bus_len_a;
    logic [31:0] bus_addr_a;
    logic [7:0]  bus_wdata_a, bus_rdata_a;
    logic        bus_exc_a, busy_a, done_a, error_a;
    logic [1:0]  dbg_a;
    logic        exc_en_a;

    // ---------------- dut_b signals ----------------
    logic        restart_b, cpu_req_b, cpu_rw_b;
    logic [1:0]  cpu_len_b;
    logic [31:0] cpu_addr_b;
    logic [7:0]  cpu_wdata_b, cpu_rdata_b;
    logic        cpu_ready_b, cpu_exc_b;
    logic        bus_rw_b;
    logic [1:0]  bus_len_b;
    logic [31:0] bus_addr_b;
    logic [7:0]  bus_wdata_b, bus_rdata_b;
    logic        bus_exc_b, busy_b, done_b, error_b;
    logic [1:0]  dbg_b;

    // ---------------- bus model ----------------
    // Flash window returns A0+offset; everything else returns a pattern.
    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        logic [31:0] off;
        off = a - SRC;
        if (off < 32'd1024) return 8'hA0 + off[7:0];
        return 8'hC3 ^ a[7:0];
    endfunction

    assign bus_rdata_a = mem_rd(bus_addr_a);
    assign bus_exc_a   = (exc_en_a && !bus_rw_a && bus_addr_a == SRC + 32'd2) ||
                         (bus_addr_a == BAD);
    assign bus_rdata_b = mem_rd(bus_addr_b);
    assign bus_exc_b   = 1'b0;

    boot_copy_ctrl #(.SRC_BASE(SRC), .DST_BASE(DST), .COPY_LEN(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst_a), .restart(restart_a),
        .cpu_req(cpu_req_a), .cpu_rw(cpu_rw_a), .cpu_len(cpu_len_a),
        .cpu_addr(cpu_addr_a), .cpu_wdata(cpu_wdata_a), .cpu_rdata(cpu_rdata_a),
        .cpu_ready(cpu_ready_a), .cpu_exception(cpu_exc_a),
        .bus_rw(bus_rw_a), .bus_len(bus_len_a), .bus_addr(bus_addr_a),
        .bus_wdata(bus_wdata_a), .bus_rdata(bus_rdata_a), .bus_exception(bus_exc_a),
        .busy(busy_a), .done(done_a), .error(error_a), .dbg_state(dbg_a)
    );

    boot_copy_ctrl #(.SRC_BASE(SRC), .DST_BASE(DST)) dut_b (
        .clk(clk), .rst(rst_b), .restart(restart_b),
        .cpu_req(cpu_req_b), .cpu_rw(cpu_rw_b), .cpu_len(cpu_len_b),
        .cpu_addr(cpu_addr_b), .cpu_wdata(cpu_wdata_b), .cpu_rdata(cpu_rdata_b),
        .cpu_ready(cpu_ready_b), .cpu_exception(cpu_exc_b),
        .bus_rw(bus_rw_b), .bus_len(bus_len_b), .bus_addr(bus_addr_b),
        .bus_wdata(bus_wdata_b), .bus_rdata(bus_rdata_b), .bus_exception(bus_exc_b),
        .busy(busy_b), .done(done_b), .error(error_b), .dbg_state(dbg_b)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [39:0] exp_a_q[$];
    logic [39:0] exp_b_q[$];
    logic [31:0] last_wr_b = '0;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_copy_a(input int first, input int last);
        for (int i = first; i <= last; i++)
            exp_a_q.push_back({DST + 32'(i), 8'(8'hA0 + i)});
    endtask

    // Monitors: inputs change only at negedge, so the bus command sampled
    // 2ns later is the one committed at the following posedge.
    always begin
        @(negedge clk);
        #2;
        if (bus_rw_a) begin
            if (exp_a_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL wr_a unexpected: got %0h expected none", {bus_addr_a, bus_wdata_a});
            end else begin
                check("wr_a", {bus_addr_a, bus_wdata_a}, exp_a_q.pop_front());
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (bus_rw_b) begin
            last_wr_b = bus_addr_b;
            if (exp_b_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL wr_b unexpected: got %0h expected none", {bus_addr_b, bus_wdata_b});
            end else begin
                check("wr_b", {bus_addr_b, bus_wdata_b}, exp_b_q.pop_front());
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_a = 1'b1; rst_b = 1'b1; exc_en_a = 1'b0;
        restart_a = 1'b0; cpu_req_a = 1'b0; cpu_rw_a = 1'b0; cpu_len_a = 2'b00;
        cpu_addr_a = '0; cpu_wdata_a = '0;
        restart_b = 1'b0; cpu_req_b = 1'b0; cpu_rw_b = 1'b0; cpu_len_b = 2'b00;
        cpu_addr_b = '0; cpu_wdata_b = '0;
        repeat (3) @(negedge clk);
        #1;
        // Reset state
        check("rst_status", 40'({busy_a, done_a, error_a}), 40'(3'b100));
        check("rst_bus_rw", 40'(bus_rw_a), 40'(0));
        check("rst_addr", 40'(bus_addr_a), 40'(SRC));
        check("rst_state", 40'(dbg_a), 40'(0));

        // ---- Test 1: COPY_LEN=4, restart ignored while busy ----
        push_copy_a(0, 3);
        @(negedge clk);
        rst_a = 1'b0;
        for (int c = 0; c < 8; c++) begin
            restart_a = (c == 3);
            #1;
            check("t1_busy", 40'({busy_a, done_a}), 40'(2'b10));
            @(negedge clk);
        end
        restart_a = 1'b0;
        #1;
        check("t1_done", 40'({busy_a, done_a, error_a}), 40'(3'b010));
        check("t1_q_empty", 40'(exp_a_q.size()), 40'(0));

        // ---- Test 4: CPU write request held from reset ----
        @(negedge clk);
        rst_a = 1'b1;
        cpu_req_a = 1'b1; cpu_rw_a = 1'b1; cpu_len_a = 2'b10;
        cpu_addr_a = DST + 32'd50; cpu_wdata_a = 8'h77;
        @(negedge clk);
        #1;
        check("t4_rst_ready", 40'(cpu_ready_a), 40'(0));
        check("t4_rst_rw", 40'(bus_rw_a), 40'(0));
        push_copy_a(0, 3);
        exp_a_q.push_back({DST + 32'd50, 8'h77});
        @(negedge clk);
        rst_a = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("t4_ready_busy", 40'({cpu_ready_a, bus_len_a}), 40'(3'b000));
            @(negedge clk);
        end
        #1;
        check("t4_ready_done", 40'({cpu_ready_a, bus_rw_a, bus_len_a}), 40'(4'b1110));
        @(negedge clk);
        cpu_req_a = 1'b0;
        #1;
        check("t4_no_req_rw", 40'(bus_rw_a), 40'(0));
        check("t4_q_empty", 40'(exp_a_q.size()), 40'(0));

        // ---- Test 3: exception during RD of byte 2 ----
        @(negedge clk);
        rst_a = 1'b1; exc_en_a = 1'b1;
        @(negedge clk);
        push_copy_a(0, 1);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("t3_status", 40'({busy_a, done_a, error_a}), 40'(3'b001));
        check("t3_cnt_addr", 40'(bus_addr_a), 40'(SRC + 32'd2));
        check("t3_state", 40'(dbg_a), 40'(3));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            cpu_req_a = 1'b1; cpu_rw_a = 1'b1; cpu_addr_a = DST + 32'd7;
            restart_a = (c == 1);
            #1;
            check("t3_err_hold", 40'({cpu_ready_a, cpu_exc_a, bus_rw_a, error_a}), 40'(4'b0001));
        end
        @(negedge clk);
        restart_a = 1'b0; cpu_req_a = 1'b0; exc_en_a = 1'b0;
        @(negedge clk);
        #1;
        check("t3_sticky", 40'({error_a, bus_addr_a}), 40'({1'b1, SRC + 32'd2}));
        check("t3_q_empty", 40'(exp_a_q.size()), 40'(0));

        // ---- Test 5: rst pulse during byte 2 write, then full recopy ----
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        check("t3_rst_clear", 40'({busy_a, error_a}), 40'(2'b10));
        @(negedge clk);
        push_copy_a(0, 1);
        push_copy_a(0, 3);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (5) @(negedge clk);
        rst_a = 1'b1;
        #1;
        check("t5_async_rw", 40'({bus_rw_a, busy_a}), 40'(2'b01));
        check("t5_async_addr", 40'(bus_addr_a), 40'(SRC));
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("t5_busy", 40'({busy_a, done_a}), 40'(2'b10));
            @(negedge clk);
        end
        #1;
        check("t5_done", 40'({busy_a, done_a}), 40'(2'b01));
        check("t5_q_empty", 40'(exp_a_q.size()), 40'(0));

        // ---- Test 6: CPU exception, then restart with a read pending ----
        @(negedge clk);
        cpu_req_a = 1'b1; cpu_rw_a = 1'b0; cpu_addr_a = BAD;
        #1;
        check("t6_cpu_exc", 40'({cpu_exc_a, cpu_ready_a, error_a}), 40'(3'b110));
        @(negedge clk);
        cpu_addr_a = SRC + 32'd1; restart_a = 1'b1;
        push_copy_a(0, 3);
        #1;
        check("t6_rd_ready", 40'({cpu_ready_a, bus_rw_a}), 40'(2'b10));
        check("t6_rdata", 40'(cpu_rdata_a), 40'(8'hA1));
        @(negedge clk);
        restart_a = 1'b0; cpu_req_a = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("t6_busy", 40'({busy_a, done_a}), 40'(2'b10));
            @(negedge clk);
        end
        #1;
        check("t6_done", 40'({busy_a, done_a}), 40'(2'b01));
        check("t6_q_empty", 40'(exp_a_q.size()), 40'(0));

        // ---- Test 2: default COPY_LEN=261 ----
        for (int i = 0; i < 261; i++)
            exp_b_q.push_back({DST + 32'(i), 8'(8'hA0 + i)});
        @(negedge clk);
        rst_b = 1'b0;
        for (int c = 0; c < 522; c++) begin
            if (c == 521) begin
                #1;
                check("t2_not_done_521", 40'({busy_b, done_b}), 40'(2'b10));
            end
            @(negedge clk);
        end
        #1;
        check("t2_done_522", 40'({busy_b, done_b, error_b}), 40'(3'b010));
        repeat (3) @(negedge clk);
        #1;
        check("t2_last_addr", 40'(last_wr_b), 40'(DST + 32'd260));
        check("t2_q_empty", 40'(exp_b_q.size()), 40'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
